prog_encoder: RTL

Sequential MIPS instruction encoder and instruction-memory loader. It accepts symbolic instructions over a valid/ready stream and packs each one into a 32-bit MIPS machine word using the same opcode/funct set the CPU decodes (R-type ADD/SUB/AND/OR/SLT, LW, SW, ADDI, BEQ). Each word is written to consecutive instruction-memory addresses starting at 0. The CPU is held in reset until a complete program has been loaded.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/instr_encode.sv | 32 +++
 rtl/prog_encoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: the loader's encoder and the CPU's control
// unit both draw opcode/funct values from here.
package mips_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_ADDI = 4'd7,
        OP_BEQ  = 4'd8
    } op_kind_t;

    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] LW     = 6'b100011;
    localparam logic [5:0] SW     = 6'b101011;
    localparam logic [5:0] ADDI   = 6'b001000;
    localparam logic [5:0] BEQ    = 6'b000100;

    localparam logic [5:0] ADD_F  = 6'b100000;
    localparam logic [5:0] SUB_F  = 6'b100010;
    localparam logic [5:0] AND_F  = 6'b100100;
    localparam logic [5:0] OR_F   = 6'b100101;
    localparam logic [5:0] SLT_F  = 6'b101010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

endpackage

// File: rtl/instr_encode.sv
// Combinational packer: symbolic instruction fields to a 32-bit MIPS word.
// Codes outside op_kind_t yield a zero word and raise illegal.
module instr_encode
    import mips_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  word = {R_TYPE, rs, rt, rd, 5'b00000, ADD_F};
            OP_SUB:  word = {R_TYPE, rs, rt, rd, 5'b00000, SUB_F};
            OP_AND:  word = {R_TYPE, rs, rt, rd, 5'b00000, AND_F};
            OP_OR:   word = {R_TYPE, rs, rt, rd, 5'b00000, OR_F};
            OP_SLT:  word = {R_TYPE, rs, rt, rd, 5'b00000, SLT_F};
            OP_LW:   word = {LW,   rs, rt, imm};
            OP_SW:   word = {SW,   rs, rt, imm};
            OP_ADDI: word = {ADDI, rs, rt, imm};
            OP_BEQ:  word = {BEQ,  rs, rt, imm};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/prog_encoder.sv
// Instruction-memory loader: encodes streamed instructions, writes them to
// consecutive addresses from 0, and holds the CPU in reset until loaded.
module prog_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic              last_pending;

    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              at_top;
    logic              accept;
    logic              wr_ok;

    instr_encode u_enc (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // A write pending to the top address must not be followed by another
    // accept, otherwise that item would be taken and then silently dropped.
    assign at_top   = (addr == '1);
    assign in_ready = (state == LOAD) && !start && !last_pending && !(we_q && at_top);
    assign accept   = in_valid && in_ready;
    assign wr_ok    = accept && !enc_illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (start) begin
            state_d = LOAD;
        end else if (state == LOAD) begin
            if (accept && enc_illegal) begin
                state_d = ERROR;
            end else if (we_q && last_pending) begin
                state_d = DONE;
            end else if (we_q && at_top) begin
                state_d = ERROR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr         <= '0;
            count        <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            last_pending <= 1'b0;
        end else if (start) begin
            addr         <= '0;
            count        <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            last_pending <= 1'b0;
        end else begin
            if (we_q) begin
                count <= count + 1'b1;
                if (!at_top) begin
                    addr <= addr + 1'b1;
                end
            end
            we_q <= wr_ok;
            if (wr_ok) begin
                wdata_q <= enc_word;
                if (in_last) begin
                    last_pending <= 1'b1;
                end
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr;
    assign imem_wdata = wdata_q;
    assign word_count = count;
    assign done       = (state == DONE);
    assign err        = (state == ERROR);
    assign cpu_rst_n  = (state == DONE);

endmodule
